// File: rtl/keypad_pkg.sv
// Shared constants and types for the bus-mapped matrix keypad scanner.
package keypad_pkg;
  localparam int CODE_W = 4;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  // DATA register: bit 7 flags a valid code in the low nibble.
  localparam int DATA_VALID_BIT = 7;
  // STATUS register: held flag, sticky overflow, queue count in the low bits.
  localparam int STAT_HELD_BIT  = 5;
  localparam int STAT_OVF_BIT   = 4;

  typedef enum logic {
    DRIVE  = 1'b0,
    SAMPLE = 1'b1
  } scan_state_t;
endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO for key codes; a pop frees a slot for a push on the same edge.
module keypad_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/wb_keypad_scanner.sv
// Wishbone slave that scans an active-low matrix keypad, debounces each key
// and queues press codes for the CPU; irq_o is high while codes are pending.
module wb_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int WORD       = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  input  logic              we_i,
  input  logic              adr_i,
  input  logic [WORD/8-1:0] sel_i,
  input  logic [WORD-1:0]   dat_i,
  output logic              ack_o,
  output logic [WORD-1:0]   dat_o,
  output logic [COLS-1:0]   col_o,
  input  logic [ROWS-1:0]   row_i,
  output logic              irq_o
);
  localparam int KEYS  = ROWS * COLS;
  localparam int KEY_W = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [KEY_W-1:0] key_at(input int r, input logic [IDX_W-1:0] c);
    return KEY_W'(r * COLS) + KEY_W'(c);
  endfunction

  function automatic logic [COLS-1:0] col_drive(input logic [IDX_W-1:0] c);
    return ~(COLS'(1) << c);
  endfunction

  // Row synchronizer; rows idle high through the pull-ups.
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
    end
  end

  // Column scan FSM.
  scan_state_t      scan_state;
  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;

  assign next_idx = (idx == IDX_W'(COLS - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_state <= DRIVE;
      div        <= '0;
      idx        <= '0;
      col_o      <= '1;
    end else begin
      case (scan_state)
        DRIVE: begin
          col_o <= col_drive(idx);
          div   <= div + 1'b1;
          if (div == DIV_W'(SCAN_DIV - 2)) scan_state <= SAMPLE;
        end
        SAMPLE: begin
          idx        <= next_idx;
          col_o      <= col_drive(next_idx);
          div        <= '0;
          scan_state <= DRIVE;
        end
        default: scan_state <= DRIVE;
      endcase
    end
  end

  // Debounce the keys of the column being sampled.
  logic [KEYS-1:0] deb;
  logic [DB_W-1:0] db_cnt [KEYS];
  logic [ROWS-1:0] raw_col;
  logic [ROWS-1:0] flip;
  logic [ROWS-1:0] press_ev;

  always_comb begin
    raw_col = ~row_sync;
    for (int r = 0; r < ROWS; r++) begin
      flip[r] = (raw_col[r] != deb[key_at(r, idx)]) &&
                (db_cnt[key_at(r, idx)] == DB_W'(DEBOUNCE - 1));
    end
    press_ev = flip & raw_col;
  end

  // Same-column presses wait in pend and are pushed lowest row first.
  logic [ROWS-1:0]   pend;
  logic [ROWS-1:0]   pend_low;
  logic [IDX_W-1:0]  pend_col;
  logic [CODE_W-1:0] push_code;
  logic              push;

  assign pend_low = pend & (~pend + ROWS'(1));
  assign push     = |pend;

  always_comb begin
    push_code = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pend[r]) push_code = CODE_W'(r * COLS) + CODE_W'(pend_col);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb      <= '0;
      pend     <= '0;
      pend_col <= '0;
      for (int k = 0; k < KEYS; k++) db_cnt[k] <= '0;
    end else if (scan_state == SAMPLE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (raw_col[r] == deb[key_at(r, idx)]) begin
          db_cnt[key_at(r, idx)] <= '0;
        end else if (flip[r]) begin
          deb[key_at(r, idx)]    <= raw_col[r];
          db_cnt[key_at(r, idx)] <= '0;
        end else begin
          db_cnt[key_at(r, idx)] <= db_cnt[key_at(r, idx)] + 1'b1;
        end
      end
      pend     <= press_ev;
      pend_col <= idx;
    end else begin
      pend <= pend & ~pend_low;
    end
  end

  // Key-code queue.
  logic [CODE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  keypad_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (push_code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus: a request is acked on the next edge; ack_o masks the request for one cycle.
  logic            req;
  logic            clr_ovf;
  logic            ovf_set;
  logic            overflow;
  logic [WORD-1:0] data_word;
  logic [WORD-1:0] status_word;

  assign req     = stb_i & cyc_i & ~ack_o;
  assign pop     = req & ~we_i & (adr_i == ADR_DATA) & ~fifo_empty;
  assign clr_ovf = req & we_i & (adr_i == ADR_STATUS) & sel_i[0] & dat_i[STAT_OVF_BIT];
  assign ovf_set = push & fifo_full & ~pop;

  always_comb begin
    data_word = '0;
    if (!fifo_empty) begin
      data_word[DATA_VALID_BIT] = 1'b1;
      data_word[CODE_W-1:0]     = fifo_head;
    end
    status_word                = '0;
    status_word[STAT_HELD_BIT] = |deb;
    status_word[STAT_OVF_BIT]  = overflow;
    status_word[CNT_W-1:0]     = fifo_count;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      overflow <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      ack_o <= req;
      if (req && !we_i) dat_o <= (adr_i == ADR_DATA) ? data_word : status_word;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      irq_o <= ~fifo_empty;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sel_i, dat_i};
endmodule

// File: tb/tb_wb_keypad_scanner.sv
// Directed bench for wb_keypad_scanner with a behavioural keypad matrix model.
module tb_wb_keypad_scanner;
  localparam int WORD       = 16;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = COLS * SCAN_DIV;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            stb_i;
  logic            cyc_i;
  logic            we_i;
  logic            adr_i;
  logic [1:0]      sel_i;
  logic [15:0]     dat_i;
  logic            ack_o;
  logic [15:0]     dat_o;
  logic [3:0]      col_o;
  logic [3:0]      row_i;
  logic            irq_o;
  logic [15:0]     keys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        adr;
    logic [15:0] wdat;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t init_v[3];
  vec_t drain_v[7];

  wb_keypad_scanner #(
    .WORD       (WORD),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .sel_i (sel_i),
    .dat_i (dat_i),
    .ack_o (ack_o),
    .dat_o (dat_o),
    .col_o (col_o),
    .row_i (row_i),
    .irq_o (irq_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic adr, input logic [15:0] wdat,
                     output logic [15:0] rdat);
    logic got;
    got = 1'b0;
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = adr; sel_i = 2'b11; dat_i = wdat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i);
      #1;
      got = ack_o;
    end
    rdat = dat_o;
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    check("ack_seen", {15'd0, got}, 16'd1);
  endtask

  task automatic read_chk(input string name, input logic adr, input logic [15:0] exp);
    logic [15:0] d;
    bus(1'b0, adr, 16'h0000, d);
    check(name, d, exp);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [15:0] d;
    bus(v.we, v.adr, v.wdat, d);
    if (v.chk) check(name, d, v.exp);
  endtask

  task automatic press_key(input int code, input int hold_frames, input int rel_frames);
    @(negedge clk_i);
    keys[code] = 1'b1;
    repeat (hold_frames * FRAME) @(negedge clk_i);
    keys[code] = 1'b0;
    repeat (rel_frames * FRAME) @(negedge clk_i);
  endtask

  // Returns just after the edge on which column 0 is sampled (col_o moves 1110 -> 1101).
  task automatic wait_col0_sample();
    logic [3:0] prev;
    logic       seen;
    seen = 1'b0;
    prev = col_o;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (prev == 4'b1110 && col_o == 4'b1101) seen = 1'b1;
      prev = col_o;
    end
    check("col0_sample_seen", {15'd0, seen}, 16'd1);
  endtask

  initial begin
    logic [3:0]  exp_col;
    logic [15:0] d;

    init_v[0] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h0000};
    init_v[1] = '{we: 1'b0, adr: 1'b1, wdat: 16'h0000, chk: 1'b1, exp: 16'h0000};
    init_v[2] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h0000};

    drain_v[0] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h0081};
    drain_v[1] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h0086};
    drain_v[2] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h008C};
    drain_v[3] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h008B};
    drain_v[4] = '{we: 1'b0, adr: 1'b0, wdat: 16'h0000, chk: 1'b1, exp: 16'h0000};
    drain_v[5] = '{we: 1'b1, adr: 1'b1, wdat: 16'h0010, chk: 1'b0, exp: 16'h0000};
    drain_v[6] = '{we: 1'b0, adr: 1'b1, wdat: 16'h0000, chk: 1'b1, exp: 16'h0000};

    rst_i = 1'b1; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; adr_i = 1'b0;
    sel_i = 2'b00; dat_i = 16'h0000; keys = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_col", {12'd0, col_o}, 16'h000F);
    check("rst_ack", {15'd0, ack_o}, 16'd0);
    check("rst_dat", dat_o, 16'h0000);
    check("rst_irq", {15'd0, irq_o}, 16'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Column rotation, four clocks per column
    wait_col0_sample();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk_i);
        #1;
      end
      exp_col = 4'b1111;
      exp_col[(1 + i/4) % 4] = 1'b0;
      check($sformatf("col_rot_%0d", i), {12'd0, col_o}, {12'd0, exp_col});
    end

    for (int i = 0; i < 3; i++) run_vec(init_v[i], $sformatf("init_read_%0d", i));
    check("init_irq", {15'd0, irq_o}, 16'd0);

    // Single press of (r2,c1)
    press_key(9, 3, 3);
    check("press_irq", {15'd0, irq_o}, 16'd1);
    read_chk("press_status", 1'b1, 16'h0001);
    read_chk("press_data", 1'b0, 16'h0089);
    @(posedge clk_i);
    #1;
    check("press_irq_fall", {15'd0, irq_o}, 16'd0);
    read_chk("press_data_empty", 1'b0, 16'h0000);

    // Bounce shorter than the debounce window
    @(negedge clk_i);
    keys[7] = 1'b1;
    repeat (FRAME) @(negedge clk_i);
    keys[7] = 1'b0;
    repeat (3 * FRAME) @(negedge clk_i);
    read_chk("bounce_status", 1'b1, 16'h0000);

    // Overflow with five presses, then drain and clear
    press_key(1, 3, 3);
    press_key(6, 3, 3);
    press_key(12, 3, 3);
    press_key(11, 3, 3);
    press_key(15, 3, 3);
    read_chk("ovf_status", 1'b1, 16'h0014);
    for (int i = 0; i < 7; i++) run_vec(drain_v[i], $sformatf("drain_%0d", i));

    // Push into a full FIFO on the same edge as a DATA pop
    press_key(4, 3, 3);
    press_key(5, 3, 3);
    press_key(10, 3, 3);
    press_key(3, 3, 3);
    read_chk("full_status", 1'b1, 16'h0004);
    wait_col0_sample();
    keys[0] = 1'b1;
    wait_col0_sample();
    wait_col0_sample();
    bus(1'b0, 1'b0, 16'h0000, d);
    check("simul_pop_data", d, 16'h0084);
    read_chk("simul_status", 1'b1, 16'h0024);

    // Reset in the middle of a request
    keys[0] = 1'b0;
    read_chk("pre_rst_data0", 1'b0, 16'h0085);
    read_chk("pre_rst_data1", 1'b0, 16'h008A);
    bus(1'b0, 1'b1, 16'h0000, d);
    check("pre_rst_count", d & 16'h0017, 16'h0002);
    @(negedge clk_i);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 1'b0; sel_i = 2'b11;
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_ack_async", {15'd0, ack_o}, 16'd0);
    check("midrst_col_async", {12'd0, col_o}, 16'h000F);
    @(posedge clk_i);
    #1;
    check("midrst_ack", {15'd0, ack_o}, 16'd0);
    check("midrst_irq", {15'd0, irq_o}, 16'd0);
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("postrst_col", {12'd0, col_o}, 16'h000E);
    check("postrst_ack", {15'd0, ack_o}, 16'd0);
    read_chk("postrst_status", 1'b1, 16'h0000);
    read_chk("postrst_data", 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_keypad_scanner.md
Name: wb_keypad_scanner

Overview:
- Wishbone slave that scans a ROWS x COLS matrix keypad and queues debounced key-press codes in a small FIFO for the CPU.
- It is the input-side companion of the bus-mapped seven-segment display driver, and uses the same bus slave style.
- It drives keypad columns active-low in rotation and samples pull-up rows (active-low).
- irq_o flags pending keys.

Parameters:
- WORD, 16, system word size; sel_i width is WORD/8.
- ROWS, 4, keypad rows.
- COLS, 4, keypad columns; ROWS*COLS <= 16.
- SCAN_DIV, 1000, clocks each column is driven (>= 4).
- DEBOUNCE, 4, consecutive identical full-scan samples required to change a key's debounced state (>= 1).
- FIFO_DEPTH, 4, key-code queue depth (power of 2).

Ports:
- clk_i, in, 1, system clock; all logic on the rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- stb_i, in, 1, wishbone strobe.
- cyc_i, in, 1, wishbone cycle.
- we_i, in, 1, write enable.
- adr_i, in, 1, register select: 0 = DATA, 1 = STATUS.
- sel_i, in, WORD/8, byte selects.
- dat_i, in, WORD, write data.
- ack_o, out, 1, wishbone acknowledge.
- dat_o, out, WORD, read data (registered).
- col_o, out, COLS, column drive, active-low, one-hot-low.
- row_i, in, ROWS, row sense, active-low, asynchronous to clk_i.
- irq_o, out, 1, high while the FIFO is non-empty.

Behaviour:
- Reset values: col_o all ones, ack_o 0, dat_o 0, irq_o 0. FIFO empty, overflow 0, all keys released, column index 0, divider 0, debounce counters 0.
- Reset is asynchronous: asserting rst_i mid-scan or mid-bus-cycle immediately returns everything to reset values. A pending unacked request is dropped and no pop occurs.
- Row synchronizer:
  - row_i passes through a 2-FF synchronizer before use.
  - Key at (r,c) is raw-pressed when synced row r is 0 while column c is driven.
- Scan state machine, states DRIVE then SAMPLE:
  - DRIVE: col_o[idx] = 0, other columns 1; divider counts 0..SCAN_DIV-1.
  - SAMPLE: taken at divider == SCAN_DIV-1, so the rows have settled for more than 2 clocks including synchronizer latency. Raw states for all ROWS keys of column idx are captured.
  - Then idx advances, wrapping COLS-1 -> 0, and the divider resets.
  - One frame = COLS*SCAN_DIV clocks.
- Debounce, per key, evaluated at that key's column sample:
  - Raw equal to the debounced state: counter cleared.
  - Raw differs: counter increments. When it reaches DEBOUNCE, the debounced state flips and the counter clears.
  - A 0->1 debounced flip is a press event with code = r*COLS + c (4 bits). Release generates no event.
- FIFO:
  - At most one press event per clock; events only occur at a SAMPLE edge, and same-column keys are pushed lowest row first over consecutive cycles via a ROWS-bit pending mask.
  - Push when full: code dropped, overflow set (sticky).
  - Push and pop in the same cycle: both occur, count unchanged. A full FIFO with a simultaneous pop accepts the push with no overflow.
- Bus:
  - A request is stb_i & cyc_i & ~ack_o. On that edge ack_o <= 1, and on the next edge ack_o <= 0. One ack per request, latency 1 clock.
  - Read DATA: dat_o <= {0, nonempty at bit 7, code at [3:0]}; pops the head if non-empty. Reading an empty FIFO returns 0 and pops nothing.
  - Read STATUS: dat_o <= {0, any_key_held[5], overflow[4], count[2:0]}.
  - Write STATUS with sel_i[0] & dat_i[4]: clears overflow. Overflow set and clear in the same cycle: set wins.
  - Write DATA: ignored, acked.
- irq_o is registered: it equals the FIFO non-empty flag, updated the cycle after push or pop.

Decomposition:
- Package keypad_pkg holds:
  - the key-code width constant (4);
  - register address localparams ADR_DATA = 0 and ADR_STATUS = 1;
  - STATUS bit positions;
  - the scan-state enum {DRIVE, SAMPLE}.
- One sub-module, keypad_fifo: parameterised sync FIFO with push, pop, full, empty and count, and simultaneous push/pop support.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, COLS=ROWS=4):
- Reset: col_o cycles 1110, 1101, 1011, 0111, every 4 clocks, wrapping. Reads of DATA return 0x0000; irq_o = 0.
- Press key (r2,c1), held 3 frames: exactly one code 0x9 is queued and irq_o rises. A DATA read returns 0x0089 and irq_o falls; a second read returns 0x0000.
- Key bounces, pressed for 1 frame then released: no event; STATUS count stays 0.
- Press 5 distinct keys with no reads: STATUS reads 0x0014 (overflow, count 4); the first 4 codes come out in press order. Writing STATUS 0x0010 gives a STATUS read of 0x0000 after draining.
- Press and hold (r0,c0) while issuing a DATA read on the same edge as the push into a full FIFO: count stays 4 and overflow stays 0.
- Assert rst_i mid-request while the FIFO holds 2 codes: ack_o stays low, count reads 0 and col_o = 1110 after release.
